// File: rtl/svnet_running_min.sv
// svnet_running_min
//   Streaming signed min-reduction placed after the parallel tree-min. It folds
//   BEATS valid input words into one running minimum. When the reduction is
//   complete it emits the minimum and the beat position where that minimum
//   first occurred.
//
//   Optional feature: SVNET_RUNNING_MIN_ARGMIN_EN
//     defined   - the argmin index is tracked and reported on o_index
//     undefined - no index storage is built and o_index is tied to 0
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   i_data_valid input beat qualifier (no backpressure)
//   i_data       signed input word
//   i_flush      discard the partial reduction
//   o_data_valid one-cycle pulse per completed reduction
//   o_data       signed minimum of the completed reduction
//   o_index      beat position of the minimum (0..BEATS-1)
//   o_busy       a partial reduction is held (registered cnt != 0)
module svnet_running_min #(
   parameter int WIDTH = 1,
   parameter int BEATS = 1,
   localparam int IDX_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_data_valid,
   input  logic [WIDTH-1:0]     i_data,
   input  logic                 i_flush,
   output logic                 o_data_valid,
   output logic [WIDTH-1:0]     o_data,
   output logic [IDX_WIDTH-1:0] o_index,
   output logic                 o_busy
);

   localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(BEATS - 1);

   logic [IDX_WIDTH-1:0] cnt, cnt_nxt, beat_idx;
   logic [WIDTH-1:0]     acc, acc_nxt;
   logic                 take, is_final;

   always_comb begin
      // A flush turns any concurrent beat into beat 0 of a fresh reduction.
      beat_idx = (i_flush || cnt == '0) ? '0 : cnt;
      // Beat 0 always loads. Later beats load only if strictly smaller, so
      // that on a tie the earlier index is kept.
      take     = (beat_idx == '0) || ($signed(i_data) < $signed(acc));
      acc_nxt  = take ? i_data : acc;
      is_final = (beat_idx == LAST);
      cnt_nxt  = cnt;
      if (i_data_valid)
         cnt_nxt = is_final ? '0 : beat_idx + 1'b1;
      else if (i_flush)
         cnt_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         acc          <= '0;
         o_data_valid <= 1'b0;
         o_data       <= '0;
         o_busy       <= 1'b0;
      end else begin
         cnt          <= cnt_nxt;
         o_busy       <= (cnt_nxt != '0);
         o_data_valid <= i_data_valid && is_final;
         if (i_data_valid) begin
            acc <= acc_nxt;
            if (is_final)
               o_data <= acc_nxt;
         end
      end
   end

`ifdef SVNET_RUNNING_MIN_ARGMIN_EN
   logic [IDX_WIDTH-1:0] acc_idx, idx_nxt;

   assign idx_nxt = take ? beat_idx : acc_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_idx <= '0;
         o_index <= '0;
      end else if (i_data_valid) begin
         acc_idx <= idx_nxt;
         if (is_final)
            o_index <= idx_nxt;
      end
   end
`else
   assign o_index = '0;
`endif

   a_single_pulse: assert property (@(posedge clk) disable iff (rst)
      ((BEATS > 1) && o_data_valid) |=> !o_data_valid);

   a_cnt_range: assert property (@(posedge clk) disable iff (rst)
      int'(cnt) < BEATS);

endmodule
